// File: rtl/msg_stream_pkg.sv
// Shared types and constant message table for the message stream sequencer.
// The ROM holds ASCII messages zero-padded to ROM_MAX_LEN characters.
package msg_stream_pkg;

  localparam int ROM_DATA_W  = 8;
  localparam int ROM_NUM_MSG = 4;
  localparam int ROM_MAX_LEN = 16;
  localparam int ROM_SEL_W   = $clog2(ROM_NUM_MSG);
  localparam int ROM_IDX_W   = $clog2(ROM_MAX_LEN);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  typedef logic [ROM_DATA_W-1:0] char_t;

  localparam char_t MSG_ROM [ROM_NUM_MSG][ROM_MAX_LEN] = '{
    // "Guatemala"
    '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C,
      8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Quetzal"
    '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Zacapa"
    '{8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    // "Tikal"
    '{8'h54, 8'h69, 8'h6B, 8'h61, 8'h6C, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  localparam int unsigned MSG_LEN [ROM_NUM_MSG] = '{9, 7, 6, 5};

  function automatic bit msg_lens_ok();
    for (int m = 0; m < ROM_NUM_MSG; m++) begin
      if (MSG_LEN[m] == 0 || MSG_LEN[m] > ROM_MAX_LEN) return 1'b0;
    end
    return 1'b1;
  endfunction

  localparam bit LEN_OK = msg_lens_ok();

  // Out-of-range message numbers fall back to message 0.
  function automatic logic [ROM_SEL_W-1:0] sel_clamp(input logic [ROM_SEL_W-1:0] s);
    return (int'(s) >= ROM_NUM_MSG) ? '0 : s;
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational message lookup: character at (sel, idx) and whether it is
// the last character of that message.
module msg_rom
  import msg_stream_pkg::*;
(
  input  logic [ROM_SEL_W-1:0]  sel,
  input  logic [ROM_IDX_W-1:0]  idx,
  output logic [ROM_DATA_W-1:0] ch,
  output logic                  is_last
);

  assign ch      = MSG_ROM[sel][idx];
  assign is_last = (int'(idx) == int'(MSG_LEN[sel]) - 1);

endmodule

// File: rtl/msg_stream_seq.sv
// Streams a stored ASCII message over valid/ready, one character per accepted
// beat, in one-shot or loop mode with start/stop control and a done pulse.
module msg_stream_seq
  import msg_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 16,
  parameter int SEL_W   = $clog2(NUM_MSG),
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [SEL_W-1:0]  select,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] q_out,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              q_last,
  output logic              busy,
  output logic              done
);

  // The message table is fixed in the package; reject mismatched builds.
  if (!LEN_OK || DATA_W != ROM_DATA_W || NUM_MSG != ROM_NUM_MSG ||
      MAX_LEN != ROM_MAX_LEN || SEL_W != ROM_SEL_W || IDX_W != ROM_IDX_W) begin : g_cfg_err
    $error("msg_stream_seq: parameters or message lengths do not match the message table");
  end

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  cur_sel;
  logic              stop_pend;
  logic              acc;
  logic              term;
  logic [SEL_W-1:0]  rom_sel;
  logic [IDX_W-1:0]  rom_idx;
  logic [DATA_W-1:0] rom_ch;
  logic              rom_last;

  assign acc  = q_valid & q_ready & en;
  assign term = mode | stop_pend | stop;

  // Address of the character to load on the next transfer: a fresh message
  // from IDLE or at the loop wrap, otherwise the following character.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    rom_sel = cur_sel;
    rom_idx = idx + 1'b1;
    if (state == IDLE || q_last) begin
      rom_sel = sel_clamp(select);
      rom_idx = '0;
    end
  end

  msg_rom u_rom (
    .sel     (rom_sel),
    .idx     (rom_idx),
    .ch      (rom_ch),
    .is_last (rom_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (acc && q_last && term) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == STREAM);
    q_valid = (state == STREAM);
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      cur_sel   <= '0;
      stop_pend <= 1'b0;
      q_out     <= '0;
      q_last    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_sel <= rom_sel;
            idx     <= '0;
            q_out   <= rom_ch;
            q_last  <= rom_last;
          end
        end
        STREAM: begin
          if (stop) stop_pend <= 1'b1;
          if (acc) begin
            if (q_last && term) begin
              q_out  <= '0;
              q_last <= 1'b0;
            end else begin
              // Mid-message advance or loop wrap; cur_sel only changes on wrap.
              if (q_last) cur_sel <= rom_sel;
              idx    <= rom_idx;
              q_out  <= rom_ch;
              q_last <= rom_last;
            end
          end
        end
        DONE: begin
          stop_pend <= 1'b0;
          idx       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_stream_seq.sv
// Directed bench for msg_stream_seq: one-shot, backpressure, enable stall,
// loop with select change, stop, and mid-stream reset.
module tb_msg_stream_seq;

  localparam int DATA_W  = 8;
  localparam int NUM_MSG = 4;
  localparam int MAX_LEN = 16;
  localparam int SEL_W   = 2;
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [SEL_W-1:0]  select;
  logic              mode;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] q_out;
  logic              q_valid;
  logic              q_ready;
  logic              q_last;
  logic              busy;
  logic              done;

  int n_vec  = 0;
  int n_miss = 0;

  // Hand-written ASCII of the four messages.
  logic [7:0] exp_chr [4][9] = '{
    '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61},
    '{8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h6C, 8'h00, 8'h00},
    '{8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h00, 8'h00, 8'h00},
    '{8'h54, 8'h69, 8'h6B, 8'h61, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h00}
  };
  int exp_len [4] = '{9, 7, 6, 5};

  always #5 clk = ~clk;

  msg_stream_seq #(
    .DATA_W (DATA_W), .NUM_MSG (NUM_MSG), .MAX_LEN (MAX_LEN),
    .SEL_W  (SEL_W),  .IDX_W   (IDX_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .select  (select),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .q_out   (q_out),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .q_last  (q_last),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [SEL_W-1:0] sel, input logic md);
    select = sel;
    mode   = md;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; mode = 1'b1; start = 1'b0; stop = 1'b0;
    q_ready = 1'b0; select = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({q_out, q_valid, q_last, busy, done} !== 12'h000) begin
      $display("FAIL reset_outputs: got q_out=%h v=%b l=%b busy=%b done=%b, want all 0",
               q_out, q_valid, q_last, busy, done);
      n_miss++;
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if ({q_valid, busy, done} !== 3'b000) begin
      $display("FAIL reset_idle: got v=%b busy=%b done=%b, want 000", q_valid, busy, done);
      n_miss++;
    end
  endtask

  task automatic test_oneshot();
    q_ready = 1'b1;
    kick(2'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (q_valid !== 1'b1 || busy !== 1'b1 || q_out !== exp_chr[0][i] || q_last !== (i == 8)) begin
        $display("FAIL oneshot_beat%0d: got v=%b busy=%b q_out=%h last=%b, want v=1 busy=1 q_out=%h last=%b",
                 i, q_valid, busy, q_out, q_last, exp_chr[0][i], (i == 8));
        n_miss++;
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || q_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL oneshot_done: got done=%b v=%b busy=%b, want done=1 v=0 busy=0", done, q_valid, busy);
      n_miss++;
    end
    start = 1'b1;   // start during DONE must be ignored
    tick();
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || q_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL oneshot_idle: got done=%b v=%b busy=%b, want 000", done, q_valid, busy);
      n_miss++;
    end
    tick();
    n_vec++;
    if (q_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL start_in_done_ignored: got v=%b busy=%b, want 00", q_valid, busy);
      n_miss++;
    end
  endtask

  // use_en=0: q_ready toggles each cycle. use_en=1: q_ready=1, en low 3 cycles.
  task automatic test_backpressure(input bit use_en);
    int  beat;
    bit  acc;
    beat = 0;
    q_ready = 1'b1; en = 1'b1;
    kick(2'd1, 1'b1);
    for (int cyc = 0; cyc < 40 && beat < 7; cyc++) begin
      n_vec++;
      if (q_valid !== 1'b1 || q_out !== exp_chr[1][beat] || q_last !== (beat == 6)) begin
        $display("FAIL %s_cyc%0d: got v=%b q_out=%h last=%b, want v=1 q_out=%h last=%b",
                 use_en ? "en_stall" : "backpressure", cyc, q_valid, q_out, q_last,
                 exp_chr[1][beat], (beat == 6));
        n_miss++;
      end
      if (use_en) begin
        q_ready = 1'b1;
        en      = !(cyc >= 2 && cyc < 5);
      end else begin
        q_ready = (cyc % 2 == 0);
        en      = 1'b1;
      end
      acc = q_ready && en;
      tick();
      if (acc) beat++;
    end
    q_ready = 1'b1; en = 1'b1;
    n_vec++;
    if (beat != 7 || done !== 1'b1) begin
      $display("FAIL %s_end: got beats=%0d done=%b, want beats=7 done=1",
               use_en ? "en_stall" : "backpressure", beat, done);
      n_miss++;
    end
    tick();
  endtask

  // Loop Tikal twice, switch select to Zacapa mid-message; ends on Zacapa[1].
  task automatic test_loop();
    int m, i;
    q_ready = 1'b1;
    kick(2'd3, 1'b0);
    for (int k = 0; k < 11; k++) begin
      m = (k < 10) ? 3 : 2;
      i = (k < 10) ? k % 5 : 0;
      n_vec++;
      if (q_valid !== 1'b1 || busy !== 1'b1 || q_out !== exp_chr[m][i] ||
          q_last !== (i == exp_len[m] - 1)) begin
        $display("FAIL loop_beat%0d: got v=%b busy=%b q_out=%h last=%b, want v=1 busy=1 q_out=%h last=%b",
                 k, q_valid, busy, q_out, q_last, exp_chr[m][i], (i == exp_len[m] - 1));
        n_miss++;
      end
      if (k == 6) select = 2'd2;
      tick();
    end
  endtask

  task automatic test_stop();
    for (int i = 1; i < 6; i++) begin
      n_vec++;
      if (q_valid !== 1'b1 || q_out !== exp_chr[2][i] || q_last !== (i == 5)) begin
        $display("FAIL stop_beat%0d: got v=%b q_out=%h last=%b, want v=1 q_out=%h last=%b",
                 i, q_valid, q_out, q_last, exp_chr[2][i], (i == 5));
        n_miss++;
      end
      stop = (i == 1);
      tick();
      stop = 1'b0;
    end
    n_vec++;
    if (done !== 1'b1 || q_valid !== 1'b0) begin
      $display("FAIL stop_done: got done=%b v=%b, want done=1 v=0", done, q_valid);
      n_miss++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL stop_no_restart%0d: got v=%b busy=%b done=%b, want 000", c, q_valid, busy, done);
        n_miss++;
      end
    end
  endtask

  task automatic test_reset_mid();
    q_ready = 1'b1;
    kick(2'd0, 1'b1);
    repeat (4) tick();
    n_vec++;
    if (q_out !== 8'h65 || q_valid !== 1'b1) begin
      $display("FAIL rmid_pre: got q_out=%h v=%b, want q_out=65 v=1", q_out, q_valid);
      n_miss++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || q_out !== 8'h00 || q_last !== 1'b0) begin
      $display("FAIL rmid_async: got v=%b busy=%b q_out=%h last=%b, want all 0", q_valid, busy, q_out, q_last);
      n_miss++;
    end
    tick();
    reset_n = 1'b1;
    n_vec++;
    if (done !== 1'b0) begin
      $display("FAIL rmid_no_done_in_reset: got done=%b, want 0", done);
      n_miss++;
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || q_valid !== 1'b0) begin
      $display("FAIL rmid_no_done_after: got done=%b v=%b, want 00", done, q_valid);
      n_miss++;
    end
    kick(2'd3, 1'b1);
    n_vec++;
    if (q_valid !== 1'b1 || q_out !== 8'h54) begin
      $display("FAIL rmid_restart: got v=%b q_out=%h, want v=1 q_out=54", q_valid, q_out);
      n_miss++;
    end
    kick(2'd0, 1'b1);   // start while busy must be ignored
    for (int i = 1; i < 5; i++) begin
      n_vec++;
      if (q_valid !== 1'b1 || q_out !== exp_chr[3][i] || q_last !== (i == 4)) begin
        $display("FAIL rmid_busy_start%0d: got v=%b q_out=%h last=%b, want v=1 q_out=%h last=%b",
                 i, q_valid, q_out, q_last, exp_chr[3][i], (i == 4));
        n_miss++;
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1) begin
      $display("FAIL rmid_done: got done=%b, want 1", done);
      n_miss++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_loop();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
